// File: rtl/arbiter_edge_rr.sv
// N-way request/grant arbiter with build-time fixed-priority or round-robin selection,
// edge-qualified pending requests, bounded grant tenure and timeout pulse.
`timescale 1ns/1ps
module arbiter_edge_rr #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int EDGE     = 1,
  parameter int MAX_HOLD = 8,
  localparam int ID_W    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   ID_MAX    = ID_W'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [N-1:0]      req_prev, pending, pending_nxt;
  logic [N-1:0]      req_edge, elig, gnt_nxt;
  logic [ID_W-1:0]   id_nxt, rr_ptr, rr_nxt, win;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              timeout_nxt, win_found;

  assign gnt_valid = |gnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
      req_prev <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      timeout  <= timeout_nxt;
      req_prev <= req;
      pending  <= pending_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Winner search: lowest index, or first eligible at/after rr_ptr with wrap.
  always_comb begin
    req_edge  = req & ~req_prev;
    elig      = (EDGE != 0) ? ((pending | req_edge) & req) : req;
    win       = '0;
    win_found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned idx;
      idx = (MODE != 0) ? (int'(rr_ptr) + off) : off;
      if (idx >= N) idx = idx - N;
      if (elig[idx] && !win_found) begin
        win       = ID_W'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    timeout_nxt = 1'b0;
    rr_nxt      = rr_ptr;
    hold_nxt    = hold_cnt;
    pending_nxt = (EDGE != 0) ? ((pending | req_edge) & req) : '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt        = GRANT;
          gnt_nxt          = {{(N-1){1'b0}}, 1'b1} << win;
          id_nxt           = win;
          hold_nxt         = '0;
          rr_nxt           = (win == ID_MAX) ? '0 : win + 1'b1;
          pending_nxt[win] = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_id]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          id_nxt    = '0;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          id_nxt      = '0;
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
